run_monitor: RTL and testbench
==============================

Name: run_monitor

Overview:
- Synthesizable, parametrised successor to the simulation-only clock/cycle-counter block.
- Counts processor cycles from a start command until one of N_SRC halt sources asserts or a programmable cycle budget expires.
- Reports total cycles, stalled cycles, which source halted, and a one-shot completion pulse.
- Sits beside the CPU core; the testbench or a debug port reads its outputs instead of relying on $display/$finish.

Parameters:
- CNT_W, 16, width of both cycle counters.
- TIMEOUT, 30000, cycle budget; 0 disables the timeout; must be < 2**CNT_W.
- N_SRC, 1, number of independent halt inputs.
- SRC_W, $clog2(N_SRC>1?N_SRC:2), width of halt_id.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  begin a run (from IDLE) or restart (from HALTED/TIMEOUT).
- pause  in  1  core stalled this cycle; counted separately.
- halt  in  N_SRC  per-source halt request, level-sensitive.
- cycles  out  CNT_W  cycles elapsed in the current or last run.
- stall_cycles  out  CNT_W  cycles within the run where pause=1.
- state  out  2  0=IDLE, 1=RUN, 2=HALTED, 3=TIMEOUT.
- done  out  1  state is HALTED or TIMEOUT.
- done_pulse  out  1  high for exactly one cycle on entry to HALTED or TIMEOUT.
- timed_out  out  1  state is TIMEOUT.
- halt_id  out  SRC_W  lowest-index halt bit seen on the halting edge.

Behaviour:
- Reset (asynchronous, any state, mid-run included):
  - state=IDLE; cycles, stall_cycles and halt_id = 0; done_pulse=0.
  - No pulse is generated on reset exit.
- IDLE:
  - start=1 -> RUN next edge, with cycles and stall_cycles cleared to 0.
  - halt and pause are ignored.
- RUN, evaluated each posedge in strict priority order:
  - 1. Any halt bit = 1 -> HALTED. halt_id = lowest set index. Counters are NOT incremented on this edge, matching the legacy rule (report the count, then stop).
  - 2. Else if TIMEOUT != 0 and cycles == TIMEOUT -> TIMEOUT state. Counters hold. halt_id unchanged (0).
  - 3. Else cycles <= cycles+1; if pause=1, stall_cycles <= stall_cycles+1.
- Simultaneous events:
  - halt on the same edge as the timeout condition -> HALTED wins.
  - start while in RUN is ignored.
- HALTED / TIMEOUT:
  - Sticky; counters and halt_id frozen.
  - start=1 -> RUN next edge, counters and halt_id cleared.
  - halt still asserted after the restart is honoured on the first RUN edge: HALTED again with cycles=0.
- done_pulse is registered and asserts on the edge where state enters HALTED or TIMEOUT. It drops the following edge regardless of inputs.
- Counters never wrap: TIMEOUT < 2**CNT_W. With TIMEOUT=0 they saturate at all-ones and stay in RUN.
- stall_cycles <= cycles is an invariant.
- Outputs are registered or pure decodes of state. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package holds the state encoding constants (ST_IDLE, ST_RUN, ST_HALTED, ST_TIMEOUT) and the default TIMEOUT (30000), so the testbench and debug logic use the same values.
- One natural sub-module: sat_counter (CNT_W, enable, clear, saturate), instanced twice for cycles and stall_cycles.
- The priority encoder for halt_id stays inline.

Test Plan:
- Basic halt: reset, then start pulse. Assert halt[0] 10 edges after entering RUN -> HALTED, cycles=10, halt_id=0, done_pulse high for exactly 1 cycle, done stays 1.
- Timeout: TIMEOUT=20, no halt -> TIMEOUT state when cycles==20, timed_out=1, one done_pulse, cycles holds 20 for 50 more cycles.
- Priority and encoding: N_SRC=4, halt=4'b1010 on the same edge as cycles==TIMEOUT -> HALTED (not TIMEOUT), halt_id=1.
- Stall counting: 12 RUN cycles with pause high on 5 of them, then halt -> cycles=12, stall_cycles=5.
- Restart and reset mid-run: start from HALTED -> counters back to 0, RUN. Assert reset asynchronously at cycles=7 -> state=IDLE and counters 0 before the next posedge, no done_pulse.
- Disabled timeout: TIMEOUT=0, CNT_W=4, run 40 cycles -> state RUN, cycles saturates at 15.

Source files
------------

// File: rtl/run_monitor_pkg.sv
// Shared encodings for run_monitor: state codes and the default cycle budget.
// Imported by the monitor and by anything that decodes its state output.
package run_monitor_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam int DEFAULT_TIMEOUT = 30000;

endpackage

// File: rtl/run_monitor_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
// Clear has priority over enable; one-cycle update latency, no backpressure.
module run_monitor_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_monitor.sv
// Counts run cycles and stalled cycles from start until a halt source fires or the budget expires.
// All outputs are registered or decoded from registered state; done_pulse marks the terminal-state entry edge.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int N_SRC   = 1,
    parameter int SRC_W   = $clog2(N_SRC > 1 ? N_SRC : 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic [N_SRC-1:0] halt,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state,
    output logic             done,
    output logic             done_pulse,
    output logic             timed_out,
    output logic [SRC_W-1:0] halt_id
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    logic [1:0]       state_q, state_d;
    logic [SRC_W-1:0] halt_id_q, halt_id_d;
    logic             pulse_q, pulse_d;
    logic             cnt_clr, cyc_en, stall_en;
    logic [SRC_W-1:0] halt_lo;

    always_comb begin
        halt_lo = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (halt[i]) halt_lo = SRC_W'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        halt_id_d = halt_id_q;
        cnt_clr   = 1'b0;
        cyc_en    = 1'b0;
        stall_en  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Halt beats the budget; counters freeze on the halting edge.
                if (|halt) begin
                    state_d   = ST_HALTED;
                    halt_id_d = halt_lo;
                end else if ((TIMEOUT != 0) && (cycles == TO_CNT)) begin
                    state_d = ST_TIMEOUT;
                end else begin
                    cyc_en   = 1'b1;
                    stall_en = pause;
                end
            end
            default: begin
                if (start) begin
                    state_d   = ST_RUN;
                    halt_id_d = '0;
                    cnt_clr   = 1'b1;
                end
            end
        endcase
    end

    assign pulse_d = (state_q == ST_RUN) &&
                     ((state_d == ST_HALTED) || (state_d == ST_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            halt_id_q <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            halt_id_q <= halt_id_d;
            pulse_q   <= pulse_d;
        end
    end

    run_monitor_sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (cyc_en),
        .cnt_o (cycles)
    );

    run_monitor_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr_i (cnt_clr),
        .en_i  (stall_en),
        .cnt_o (stall_cycles)
    );

    assign state      = state_q;
    assign done       = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
    assign timed_out  = (state_q == ST_TIMEOUT);
    assign done_pulse = pulse_q;
    assign halt_id    = halt_id_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: a 4-source instance with a 20-cycle budget and a
// 4-bit instance with the budget disabled.
module tb_run_monitor;
    import run_monitor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: CNT_W=16, TIMEOUT=20, N_SRC=4
    logic        a_rst, a_start, a_pause;
    logic [3:0]  a_halt;
    logic [15:0] a_cycles, a_stall;
    logic [1:0]  a_state;
    logic        a_done, a_done_pulse, a_timed_out;
    logic [1:0]  a_halt_id;

    // instance B: CNT_W=4, TIMEOUT=0, N_SRC=1
    logic        b_rst, b_start, b_pause;
    logic [0:0]  b_halt;
    logic [3:0]  b_cycles, b_stall;
    logic [1:0]  b_state;
    logic        b_done, b_done_pulse, b_timed_out;
    logic [0:0]  b_halt_id;

    run_monitor #(.CNT_W(16), .TIMEOUT(20), .N_SRC(4)) u_dut_a (
        .clk(clk), .reset(a_rst), .start(a_start), .pause(a_pause), .halt(a_halt),
        .cycles(a_cycles), .stall_cycles(a_stall), .state(a_state), .done(a_done),
        .done_pulse(a_done_pulse), .timed_out(a_timed_out), .halt_id(a_halt_id)
    );

    run_monitor #(.CNT_W(4), .TIMEOUT(0), .N_SRC(1)) u_dut_b (
        .clk(clk), .reset(b_rst), .start(b_start), .pause(b_pause), .halt(b_halt),
        .cycles(b_cycles), .stall_cycles(b_stall), .state(b_state), .done(b_done),
        .done_pulse(b_done_pulse), .timed_out(b_timed_out), .halt_id(b_halt_id)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    typedef struct {
        logic [1:0] st;
        int         cyc;
        int         stl;
        int         id;
    } exp_t;

    exp_t sb[$];

    task automatic expect_end(input logic [1:0] st, input int cyc, input int stl, input int id);
        exp_t e;
        e.st = st; e.cyc = cyc; e.stl = stl; e.id = id;
        sb.push_back(e);
    endtask

    // Scoreboard side: every done_pulse retires one expected terminal result.
    logic prev_pulse = 1'b0;
    always @(negedge clk) begin
        if (prev_pulse) chk("pulse_width", 32'(a_done_pulse), 0);
        if (a_done_pulse && !prev_pulse) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("end_state",   32'(a_state),     32'(e.st));
                chk("end_cycles",  32'(a_cycles),    32'(e.cyc));
                chk("end_stalls",  32'(a_stall),     32'(e.stl));
                chk("end_halt_id", 32'(a_halt_id),   32'(e.id));
                chk("end_done",    32'(a_done),      1);
                chk("end_tmo",     32'(a_timed_out), (e.st == ST_TIMEOUT) ? 1 : 0);
            end
        end
        prev_pulse <= a_done_pulse;
    end

    task automatic a_go();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic a_run(input int n, input int npause);
        for (int i = 0; i < n; i++) begin
            a_pause = (i < npause);
            @(negedge clk);
        end
        a_pause = 1'b0;
    endtask

    task automatic a_hit(input logic [3:0] v);
        a_halt = v;
        @(negedge clk);
        a_halt = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_pause = 1'b0; a_halt = '0;
        b_rst = 1'b1; b_start = 1'b0; b_pause = 1'b0; b_halt = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state",  32'(a_state),      32'(ST_IDLE));
        chk("rst_cycles", 32'(a_cycles),     0);
        chk("rst_stall",  32'(a_stall),      0);
        chk("rst_id",     32'(a_halt_id),    0);
        chk("rst_pulse",  32'(a_done_pulse), 0);
        chk("rst_done",   32'(a_done),       0);
        a_rst = 1'b0; b_rst = 1'b0;
        repeat (2) @(negedge clk);

        // basic halt after 10 counted edges
        a_go();
        chk("run_entry", 32'(a_state), 32'(ST_RUN));
        expect_end(ST_HALTED, 10, 0, 0);
        a_run(10, 0);
        a_hit(4'b0001);
        repeat (3) @(negedge clk);
        chk("halt_sticky_done",  32'(a_done),   1);
        chk("halt_sticky_cyc",   32'(a_cycles), 10);
        chk("halt_sticky_state", 32'(a_state),  32'(ST_HALTED));

        // restart clears counters; stall counting; highest source only
        a_go();
        chk("restart_cyc",   32'(a_cycles),  0);
        chk("restart_id",    32'(a_halt_id), 0);
        chk("restart_state", 32'(a_state),   32'(ST_RUN));
        expect_end(ST_HALTED, 12, 5, 3);
        a_run(12, 5);
        a_hit(4'b1000);

        // budget expiry, then hold for 50 cycles
        a_go();
        expect_end(ST_TIMEOUT, 20, 0, 0);
        a_run(21, 0);
        repeat (50) @(negedge clk);
        chk("tmo_hold_cyc",   32'(a_cycles),    20);
        chk("tmo_hold_state", 32'(a_state),     32'(ST_TIMEOUT));
        chk("tmo_hold_flag",  32'(a_timed_out), 1);

        // halt coincident with budget expiry wins; start mid-run ignored
        a_go();
        expect_end(ST_HALTED, 20, 0, 1);
        a_run(10, 0);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_run(9, 0);
        chk("start_in_run_ignored", 32'(a_cycles), 20);
        a_hit(4'b1010);

        // restart with halt held: halts again on first RUN edge at cycles=0
        expect_end(ST_HALTED, 0, 0, 2);
        a_halt = 4'b0100;
        a_go();
        @(negedge clk);
        a_halt = '0;

        // asynchronous reset mid-run at cycles=7
        a_go();
        a_run(7, 0);
        chk("pre_rst_cyc", 32'(a_cycles), 7);
        #2 a_rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(a_state),      32'(ST_IDLE));
        chk("async_rst_cyc",   32'(a_cycles),     0);
        chk("async_rst_pulse", 32'(a_done_pulse), 0);
        @(negedge clk);
        a_rst = 1'b0;
        a_halt = 4'b1111;
        a_pause = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ignores_halt", 32'(a_state), 32'(ST_IDLE));
        chk("idle_no_count",     32'(a_stall), 0);
        a_halt = '0;
        a_pause = 1'b0;

        // disabled budget: 4-bit counters saturate, stay in RUN
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_pause = 1'b1;
        repeat (40) @(negedge clk);
        b_pause = 1'b0;
        chk("sat_state", 32'(b_state),     32'(ST_RUN));
        chk("sat_cyc",   32'(b_cycles),    15);
        chk("sat_stall", 32'(b_stall),     15);
        chk("sat_done",  32'(b_done),      0);
        chk("sat_tmo",   32'(b_timed_out), 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
